// File: rtl/sm_result_display.sv
// sm_result_display: sign-magnitude result to a cycling 7-segment digit.
// Define SM_DISP_ACTIVE_LOW_EN for inverted seg/dp (common-anode).
module sm_result_display #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_res,
  output logic [6:0] seg,
  output logic       dp,
  output logic       shown
);

`ifdef SM_DISP_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_INV = 7'h7F;
  localparam logic       DP_INV  = 1'b1;
`else
  localparam logic [6:0] SEG_INV = 7'h00;
  localparam logic       DP_INV  = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SHOW_SIGN,
    SHOW_TENS,
    SHOW_UNITS,
    GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       res;
  logic [11:0]      dd;
  logic [1:0]       iter;
  logic             first;

  logic             expire;
  logic             take;
  logic [6:0]       sign_code;
  logic [6:0]       tens_code;
  logic [6:0]       units_code;

  // dd = {tens, units, remaining binary bits}
  function automatic logic [11:0] dd_step(
    input logic [11:0] v
  );
    logic [11:0] t;
    t = v;
    if (t[7:4] >= 4'd5)
      t[7:4] = t[7:4] + 4'd3;
    if (t[11:8] >= 4'd5)
      t[11:8] = t[11:8] + 4'd3;
    return {t[10:0], 1'b0};
  endfunction

  function automatic logic [6:0] digit(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign in_ready = (state != CONV);
  assign take     = in_valid && in_ready;
  assign expire   = (cnt == LAST);

  // Negative zero is shown as positive
  assign sign_code =
    (res[5] && res[3:0] != 4'd0) ? 7'h40 : 7'h00;

  assign tens_code =
    res[4]               ? 7'h79 :
    (dd[11:8] == 4'd1)   ? 7'h06 :
                           7'h00;

  assign units_code =
    res[4] ? 7'h50 : digit(dd[7:4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      dd    <= '0;
      iter  <= '0;
      first <= 1'b0;
      seg   <= SEG_INV;
      dp    <= DP_INV;
      shown <= 1'b0;
    end else begin
      shown <= 1'b0;
      if (take) begin
        res   <= in_res;
        dd    <= {8'd0, in_res[3:0]};
        iter  <= '0;
        cnt   <= '0;
        first <= 1'b1;
        state <= CONV;
        seg   <= SEG_INV;
        dp    <= DP_INV;
      end else begin
        case (state)
          CONV: begin
            dd   <= dd_step(dd);
            iter <= iter + 2'd1;
            cnt  <= '0;
            if (iter == 2'd3) begin
              state <= SHOW_SIGN;
              seg   <= sign_code ^ SEG_INV;
              dp    <= DP_INV;
            end
          end
          SHOW_SIGN: begin
            if (expire) begin
              cnt   <= '0;
              state <= SHOW_TENS;
              seg   <= tens_code ^ SEG_INV;
              dp    <= DP_INV;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          SHOW_TENS: begin
            if (expire) begin
              cnt   <= '0;
              state <= SHOW_UNITS;
              seg   <= units_code ^ SEG_INV;
              dp    <= ~DP_INV;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          SHOW_UNITS: begin
            if (expire) begin
              cnt   <= '0;
              state <= GAP;
              seg   <= SEG_INV;
              dp    <= DP_INV;
              shown <= first;
              first <= 1'b0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          GAP: begin
            if (expire) begin
              cnt   <= '0;
              state <= SHOW_SIGN;
              seg   <= sign_code ^ SEG_INV;
              dp    <= DP_INV;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            cnt <= '0;
            seg <= SEG_INV;
            dp  <= DP_INV;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_result_display.sv
// tb_sm_result_display: scoreboard bench for sm_result_display.
// Honours SM_DISP_ACTIVE_LOW_EN when defined.
module tb_sm_result_display;

  localparam int H = 4;

`ifdef SM_DISP_ACTIVE_LOW_EN
  localparam logic [6:0] SI = 7'h7F;
  localparam logic       DI = 1'b1;
`else
  localparam logic [6:0] SI = 7'h00;
  localparam logic       DI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_res = '0;
  logic       in_ready;
  logic [6:0] seg;
  logic       dp;
  logic       shown;

  always #5 clk = ~clk;

  sm_result_display #(
    .HOLD_CYCLES(H),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_res(in_res),
    .seg(seg),
    .dp(dp),
    .shown(shown)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic       shown;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int compared = 0;
  int mismatched = 0;

  // Model: cycles since last capture (-1 = idle) and captured word
  int n = -1;
  logic [5:0] mres = '0;
  logic [6:0] dig [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic exp_t model_out();
    exp_t e;
    int p;
    int mag;
    e.seg = 7'h00;
    e.dp = 1'b0;
    e.shown = 1'b0;
    e.rdy = 1'b1;
    mag = int'(mres[3:0]);
    if (n >= 0 && n < 4) begin
      e.rdy = 1'b0;
    end else if (n >= 4) begin
      p = ((n - 4) / H) % 4;
      case (p)
        0: e.seg = (mres[5] && mag != 0) ? 7'h40 : 7'h00;
        1: e.seg = mres[4] ? 7'h79 : (mag >= 10 ? 7'h06 : 7'h00);
        2: begin
          e.seg = mres[4] ? 7'h50 : dig[mag % 10];
          e.dp = 1'b1;
        end
        default: e.seg = 7'h00;
      endcase
      e.shown = (n == 4 + 3 * H);
    end
    e.seg = e.seg ^ SI;
    e.dp = e.dp ^ DI;
    return e;
  endfunction

  task automatic step(input bit v, input logic [5:0] r);
    bit rdy;
    in_valid = v;
    in_res = r;
    @(posedge clk);
    rdy = !(n >= 0 && n < 4);
    if (v && rdy) begin
      mres = r;
      n = 0;
    end else if (n >= 0) begin
      n++;
    end
    q.push_back(model_out());
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [5:0] r, input int cycles);
    step(1'b1, r);
    repeat (cycles) step(1'b0, 6'd0);
  endtask

  task automatic check_rst(input string nm);
    compared++;
    if ({seg, dp, shown, in_ready} !== {SI, DI, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL %s: seg=%h dp=%b shown=%b rdy=%b expected seg=%h dp=%b shown=0 rdy=1",
               nm, seg, dp, shown, in_ready, SI, DI);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_rst("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = -1;
    mres = '0;
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      em = q.pop_front();
      compared++;
      if ({seg, dp, shown, in_ready} !== em) begin
        mismatched++;
        $display("FAIL out @%0t: seg=%h dp=%b shown=%b rdy=%b expected seg=%h dp=%b shown=%b rdy=%b",
                 $time, seg, dp, shown, in_ready,
                 em.seg, em.dp, em.shown, em.rdy);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_rst("reset_state");
    rst = 1'b0;
    repeat (3) step(1'b0, 6'd0);

    run(6'b000111, 4 + 8 * H);
    run(6'b101101, 4 + 2 * H);
    do_reset();
    repeat (6) step(1'b0, 6'd0);

    run(6'b101101, 4 + 8 * H);
    run(6'b100000, 4 + 4 * H);
    run(6'b001111, 4 + 4 * H);
    run(6'b010101, 4 + 4 * H);

    // Abort during SHOW_TENS
    run(6'b000011, 4 + H + 1);
    run(6'b101001, 4 + 5 * H);

    // in_valid during CONV ignored
    step(1'b1, 6'b001000);
    step(1'b0, 6'd0);
    step(1'b1, 6'b111111);
    repeat (4 + 5 * H) step(1'b0, 6'd0);

    // Capture on a phase-expiry edge
    run(6'b000101, 4 + H - 1);
    run(6'b100110, 4 + 5 * H);

    repeat (40) begin
      int hold;
      hold = $urandom_range(1, 40);
      step(1'b1, 6'($urandom_range(0, 63)));
      repeat (hold)
        step($urandom_range(0, 7) == 0, 6'($urandom_range(0, 63)));
    end

    do_reset();
    repeat (4) step(1'b0, 6'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sm_result_display.md
# sm_result_display

Downstream display stage for the 5-bit sign-magnitude adder. Accepts one 6-bit sign-magnitude result through a valid/ready handshake. Converts the 4-bit magnitude to two decimal digits with a sequential double-dabble. Drives a single 7-segment digit, cycling sign → tens → units → gap until the next result arrives.

## Interface
- HOLD_CYCLES, default 1000000: clock cycles each display phase is held; legal range 1..2^CNT_W-1.
- CNT_W, default 24: width of the hold counter.

- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_res holds a result to capture.
- in_ready  output  1  block can accept a result this cycle.
- in_res  input  6  result word:
  - bit 5: sign (1 = negative).
  - bit 4: overflow flag.
  - bits 3:0: magnitude.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high unless inverted by Configuration.
- dp  output  1  decimal point; marks the units digit.
- shown  output  1  one-cycle pulse at the end of the first full pass of a captured result.

## Operation
- States: IDLE, CONV, SHOW_SIGN, SHOW_TENS, SHOW_UNITS, GAP.
- in_ready = 1 in every state except CONV.
- Capture: in_valid && in_ready at a rising edge.
  - Registers in_res.
  - Clears the hold counter.
  - Enters CONV from any non-CONV state, aborting the current display.
  - in_valid during CONV is ignored; the result is not captured and no error is raised.
- CONV performs exactly 4 double-dabble iterations, one per cycle:
  - Each iteration adds 3 to any BCD nibble ≥5, then shifts left.
  - Produces tens ∈ {0,1} and units ∈ 0..9.
  - After the 4th iteration the FSM goes to SHOW_SIGN.
- SHOW_SIGN:
  - Shows '-' (0x40) if sign=1 and magnitude≠0.
  - Otherwise shows blank (0x00).
  - Negative zero displays as positive.
- SHOW_TENS:
  - Shows 'E' (0x79) if the overflow flag is set.
  - Otherwise shows '1' (0x06) if tens=1.
  - Otherwise shows blank; leading zero is suppressed.
- SHOW_UNITS:
  - Shows 'r' (0x50) if the overflow flag is set.
  - Otherwise shows the units digit.
  - dp=1 only in this state.
- GAP: blank, dp=0. Then returns to SHOW_SIGN; loops forever until a new capture.
- Digit codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- IDLE: seg=0x00, dp=0. Entered only from reset.
- shown pulses once per capture, on leaving SHOW_UNITS for the first time. It does not pulse on later loops.

## Timing
- Reset values: state IDLE, seg=0x00, dp=0, shown=0, in_ready=1, counter=0, digit and result registers 0.
  - Inversion per Configuration applies to the seg and dp reset values.
- seg, dp and shown are registered outputs.
- seg and dp are updated on the same edge that enters a state.
- Capture at edge k:
  - CONV occupies edges k+1..k+4.
  - SHOW_SIGN is entered at edge k+4, so seg is valid after edge k+4.
  - During CONV, seg holds blank.
- Each SHOW_* and GAP phase lasts exactly HOLD_CYCLES cycles. One full loop is 4·HOLD_CYCLES cycles.
- Capture on the same edge as a phase expiry: the capture wins.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Any captured result is discarded.

## Configuration
- SM_DISP_ACTIVE_LOW_EN
  - Defined: seg and dp are driven inverted for a common-anode display.
    - Blank = 0x7F, dp idle = 1, reset values are seg=0x7F, dp=1.
    - in_ready and shown are unaffected.
  - Undefined: active-high outputs exactly as specified above.

## Test plan
All scenarios use HOLD_CYCLES=4; codes are for active-high unless stated.
- Reset asserted mid-loop → seg=0x00, dp=0, shown=0, in_ready=1 immediately. After release the block stays in IDLE with blank output.
- in_res=6'b000111 (+7) → after 4 CONV cycles:
  - seg: 0x00 ×4, 0x00 ×4, 0x07 ×4 with dp=1, 0x00 ×4, then repeats.
  - shown pulses once, on the cycle SHOW_UNITS ends.
- in_res=6'b101101 (−13) → seg 0x40 ×4, 0x06 ×4, 0x4F ×4 with dp=1, 0x00 ×4, looping.
- in_res=6'b100000 (−0) → sign blank, tens blank, units 0x3F with dp=1. in_res=6'b001111 (+15) → blank, 0x06, 0x6D.
- in_res=6'b010101 (overflow) → blank, 0x79, 0x50 with dp=1.
- Handshake:
  - New capture during SHOW_TENS → display aborts, in_ready=0 for 4 cycles, new value shown from SHOW_SIGN.
  - in_valid pulsed during CONV → ignored; the original value is displayed.
  - Repeat the reset check with SM_DISP_ACTIVE_LOW_EN defined → seg=0x7F, dp=1.
